// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALU datapath definitions for the sum accumulator slice:
//            default widths, accumulator FSM state encoding and the
//            saturation constant used when SUM_ACC_SAT_EN is defined.
// Ports    : (package - none)
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int C_IN_W  = 11;   // ripple adder sum width
  localparam int C_ACC_W = 16;   // accumulator width
  localparam int C_CNT_W = 8;    // run length / beat counter width

  // Clamp value for a default-width accumulator in saturating builds
  localparam logic [C_ACC_W-1:0] C_SAT_VAL = {C_ACC_W{1'b1}};

  typedef enum logic [1:0] {
    SA_IDLE  = 2'd0,
    SA_ACCUM = 2'd1,
    SA_HOLD  = 2'd2
  } sa_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/sum_acc_add.sv
`default_nettype none
// ============================================================================
// Module   : sum_acc_add
// Purpose  : Combinational accumulator adder. Zero-extends the incoming
//            adder sum, adds it to the running total in ACC_W+1 bits and
//            reports the carry out of the top bit.
//            Macro SUM_ACC_SAT_EN: when defined, a carry clamps the result to
//            all-ones instead of letting it wrap modulo 2^ACC_W.
// Ports    : acc    in  ACC_W  current accumulator value
//            addend in  IN_W   incoming sum (zero-extended)
//            sum    out ACC_W  next accumulator value
//            carry  out 1      carry out of bit ACC_W-1
// Revision : 1.0  initial release
// ============================================================================
module sum_acc_add
  import alu_pkg::*;
#(
  parameter int IN_W  = C_IN_W,
  parameter int ACC_W = C_ACC_W
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [IN_W-1:0]  addend,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] w_full;

  assign w_full = {1'b0, acc} + (ACC_W+1)'(addend);
  assign carry  = w_full[ACC_W];

`ifdef SUM_ACC_SAT_EN
  // Once clamped, any further non-zero addend carries again, so the total
  // stays pinned at all-ones for the rest of the run.
  assign sum = carry ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
  assign sum = w_full[ACC_W-1:0];
`endif

endmodule : sum_acc_add
`default_nettype wire

// File: rtl/sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : sum_accumulator
// Purpose  : Accepts a run of len adder sums over a valid/ready handshake,
//            accumulates them and presents the total plus beat count under a
//            second valid/ready handshake. Overflow is sticky per run.
//            Macro SUM_ACC_SAT_EN: saturating accumulation (see sum_acc_add);
//            undefined = wrap modulo 2^ACC_W.
// Ports    : clk, rst (async active-high)
//            start, len             run request (sampled in IDLE only)
//            in_valid/in_ready/in_sum   input beat handshake
//            out_valid/out_ready        result handshake
//            out_acc, out_count, overflow  result fields
// Revision : 1.0  initial release
// ============================================================================
module sum_accumulator
  import alu_pkg::*;
#(
  parameter int IN_W  = C_IN_W,
  parameter int ACC_W = C_ACC_W,
  parameter int CNT_W = C_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow
);

  sa_state_e        r_state;
  sa_state_e        w_next;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_count;
  logic [ACC_W-1:0] r_acc;
  logic             r_overflow;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_load;
  logic             w_beat;
  logic [CNT_W-1:0] w_count_inc;
  logic [ACC_W-1:0] w_sum;
  logic             w_carry;

  assign w_count_inc = r_count + CNT_W'(1);

  sum_acc_add #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_add (
    .acc    (r_acc),
    .addend (in_sum),
    .sum    (w_sum),
    .carry  (w_carry)
  );

  // Next-state and datapath strobes
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_beat = 1'b0;
    case (r_state)
      SA_IDLE: begin
        if (start && (len != '0)) begin
          w_load = 1'b1;
          w_next = SA_ACCUM;
        end
      end
      SA_ACCUM: begin
        if (in_valid && r_in_ready) begin
          w_beat = 1'b1;
          if (w_count_inc == r_target) begin
            w_next = SA_HOLD;
          end
        end
      end
      SA_HOLD: begin
        if (r_out_valid && out_ready) begin
          w_next = SA_IDLE;
        end
      end
      default: begin
        w_next = SA_IDLE;
      end
    endcase
  end

  // Handshake flags are registered from the next state so they line up with
  // the state register exactly (out_valid rises the cycle after the last beat).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SA_IDLE;
      r_target    <= '0;
      r_count     <= '0;
      r_acc       <= '0;
      r_overflow  <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == SA_ACCUM);
      r_out_valid <= (w_next == SA_HOLD);
      if (w_load) begin
        r_target   <= len;
        r_count    <= '0;
        r_acc      <= '0;
        r_overflow <= 1'b0;
      end else if (w_beat) begin
        r_acc   <= w_sum;
        r_count <= w_count_inc;
        if (w_carry) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_acc   = r_acc;
  assign out_count = r_count;
  assign overflow  = r_overflow;

endmodule : sum_accumulator
`default_nettype wire

// File: tb/tb_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_accumulator
// Purpose  : Self-checking bench for sum_accumulator. Directed scenarios plus
//            randomized runs, compared against an arithmetic model of the
//            running total (wrap or clamp selected by SUM_ACC_SAT_EN).
// Revision : 1.0  initial release
// ============================================================================
module tb_sum_accumulator;
  import alu_pkg::*;

  localparam int IN_W  = 11;
  localparam int ACC_W = 16;
  localparam int CNT_W = 8;
  localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             overflow;

  int n_vec = 0;
  int n_bad = 0;

  sum_accumulator #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: accumulator value implied by the exact mathematical total
  function automatic logic [63:0] exp_acc(input longint total);
`ifdef SUM_ACC_SAT_EN
    return (total > ACC_MAX) ? 64'(ACC_MAX) : 64'(total);
`else
    return 64'(total % (ACC_MAX + 1));
`endif
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_acc"},   out_acc, 0);
    chk({tag, "_cnt"},   out_count, 0);
    chk({tag, "_ovf"},   overflow, 0);
    chk({tag, "_ovld"},  out_valid, 0);
    chk({tag, "_irdy"},  in_ready, 0);
  endtask

  // One complete run: bub[i] bubble cycles precede beat i; hold = cycles of
  // out_ready=0 in HOLD; noisy drives stray start/len during ACCUM/HOLD.
  task automatic run_burst(input int n, input int sums[$], input int bub[$],
                           input int hold, input bit noisy);
    longint total = 0;
    start = 1'b1; len = CNT_W'(n); in_valid = 1'b0; out_ready = 1'b0;
    cyc;
    start = 1'b0;
    chk("start_irdy", in_ready, 1);
    chk("start_ovld", out_valid, 0);
    chk("start_acc",  out_acc, 0);
    chk("start_cnt",  out_count, 0);
    chk("start_ovf",  overflow, 0);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < bub[i]; b++) begin
        in_valid = 1'b0;
        in_sum   = IN_W'($urandom_range(0, 2047));
        start    = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        len      = CNT_W'($urandom_range(1, 255));
        cyc;
        chk("bubble_cnt",  out_count, 64'(i));
        chk("bubble_acc",  out_acc, exp_acc(total));
        chk("bubble_irdy", in_ready, 1);
      end
      in_valid = 1'b1;
      in_sum   = IN_W'(sums[i]);
      start    = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      len      = CNT_W'($urandom_range(1, 255));
      cyc;
      total += sums[i];
      chk("beat_cnt", out_count, 64'(i + 1));
      chk("beat_acc", out_acc, exp_acc(total));
      chk("beat_ovf", overflow, 64'(total > ACC_MAX));
      if (i == n - 1) begin
        chk("last_ovld", out_valid, 1);
        chk("last_irdy", in_ready, 0);
      end else begin
        chk("mid_ovld", out_valid, 0);
        chk("mid_irdy", in_ready, 1);
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      in_sum    = IN_W'($urandom_range(0, 2047));
      start     = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      len       = CNT_W'($urandom_range(1, 255));
      cyc;
      chk("hold_ovld", out_valid, 1);
      chk("hold_irdy", in_ready, 0);
      chk("hold_acc",  out_acc, exp_acc(total));
      chk("hold_cnt",  out_count, 64'(n));
      chk("hold_ovf",  overflow, 64'(total > ACC_MAX));
    end
    // Handshake with a same-cycle start that must be ignored
    out_ready = 1'b1; start = 1'b1; len = CNT_W'(5); in_valid = 1'b1;
    cyc;
    chk("done_ovld", out_valid, 0);
    chk("done_irdy", in_ready, 0);
    out_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
    cyc;
    chk("after_ovld", out_valid, 0);
    chk("after_irdy", in_ready, 0);
  endtask

  initial begin
    int s[$];
    int b[$];

    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_sum = '0; out_ready = 1'b0;
    cyc; cyc;
    check_idle_zero("reset");
    rst = 1'b0;
    cyc;
    check_idle_zero("post_reset");

    // Directed: three back-to-back beats
    s = '{100, 200, 2046}; b = '{0, 0, 0};
    run_burst(3, s, b, 0, 1'b0);

    // Directed: bubbles between two beats
    s = '{5, 7}; b = '{0, 2};
    run_burst(2, s, b, 0, 1'b0);

    // Directed: long HOLD with stray beats and start pulses
    s = '{11, 22, 33, 44}; b = '{0, 1, 0, 0};
    run_burst(4, s, b, 5, 1'b1);

    // Directed: overflow run, 40 x 2046 = 81840
    s.delete(); b.delete();
    for (int i = 0; i < 40; i++) begin s.push_back(2046); b.push_back(0); end
    run_burst(40, s, b, 1, 1'b0);

    // Directed: asynchronous reset mid-run after one beat
    start = 1'b1; len = CNT_W'(3);
    cyc;
    start = 1'b0; in_valid = 1'b1; in_sum = IN_W'(500);
    cyc;
    in_valid = 1'b0;
    chk("pre_rst_acc", out_acc, 500);
    #2 rst = 1'b1;
    #1;
    check_idle_zero("async_rst");
    cyc;
    rst = 1'b0;
    cyc;
    check_idle_zero("rst_release");
    s = '{9}; b = '{0};
    run_burst(1, s, b, 0, 1'b0);

    // Directed: start with len=0 is ignored
    start = 1'b1; len = '0;
    cyc;
    start = 1'b0;
    chk("len0_irdy", in_ready, 0);
    chk("len0_ovld", out_valid, 0);
    cyc;
    chk("len0_irdy2", in_ready, 0);

    // Randomized runs, with stray start pulses during ACCUM/HOLD
    for (int r = 0; r < 12; r++) begin
      int n;
      bit big;
      n   = $urandom_range(1, 45);
      big = 1'($urandom_range(0, 1));
      s.delete(); b.delete();
      for (int i = 0; i < n; i++) begin
        s.push_back(big ? int'($urandom_range(1500, 2047)) : int'($urandom_range(0, 2047)));
        b.push_back(int'($urandom_range(0, 2)));
      end
      run_burst(n, s, b, int'($urandom_range(0, 3)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule : tb_sum_accumulator
`default_nettype wire
